// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Display back end of the parking meter. A binary seconds count is latched,
//   clamped to 9999 and converted to four BCD digits by a sequential
//   shift-add-3 (double dabble) engine, one bit per clock. A refresh counter
//   scans the four digits of a multiplexed, common-anode 7-segment display.
//   The meter can flash the whole display through blink_en / clk_blink.
//
// Parameters
//   REFRESH_DIV  clk cycles each digit slot is held before moving on
//   LZ_BLANK     1 = blank leading zero digits (the units digit is always lit)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   value_in   in   [13:0] binary seconds to display
//   load       in   one-cycle strobe: latch value_in and start a conversion
//   blink_en   in   1 = gate the display with clk_blink
//   clk_blink  in   blink phase level, sampled on clk
//   busy       out  conversion in progress (registered)
//   seg        out  [7:0] {dp,g,f,e,d,c,b,a}, active-low
//   an         out  [3:0] digit enables, active-low, an[0] = units digit
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          LZ_BLANK    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value_in,
  input  logic        load,
  input  logic        blink_en,
  input  logic        clk_blink,
  output logic        busy,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned   RCW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_DIV - 1);
  localparam logic [13:0]   MAX_VAL  = 14'd9999;
  localparam logic [3:0]    LAST_BIT = 4'd13;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } state_t;

  state_t          state_q, state_d;
  logic [13:0]     shift_q, shift_d;     // binary bits still to be shifted in
  logic [15:0]     bcd_q, bcd_d;         // BCD accumulator under construction
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     digits_q, digits_d;   // digits currently on the display
  logic [RCW-1:0]  ref_cnt_q, ref_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;

  logic [15:0]     bcd_adj;
  logic [15:0]     bcd_shifted;
  logic [3:0]      cur_digit;
  logic            lead_zero;

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Add-3 correction on every nibble that would reach 10 or more once doubled,
  // then shift the next binary bit in from the MSB of the shift register.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shifted = {bcd_adj[14:0], shift_q[13]};
  end

  // Conversion FSM.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    digits_d  = digits_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d   = (value_in > MAX_VAL) ? MAX_VAL : value_in;
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        shift_d   = {shift_q[12:0], 1'b0};
        bcd_d     = bcd_shifted;
        bit_cnt_d = bit_cnt_q + 4'd1;
        // All four digits change together on the final shift, so the display
        // never shows a half-converted value.
        if (bit_cnt_q == LAST_BIT) begin
          digits_d = bcd_shifted;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit scan and output decode.
  always_comb begin
    ref_cnt_d = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + RCW'(1);
    idx_d     = (ref_cnt_q == REF_LAST) ? idx_q + 2'd1 : idx_q;

    cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    // Current digit and everything above it are zero.
    lead_zero = (digits_q >> {idx_q, 2'b00}) == 16'd0;

    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_encode(cur_digit);
    if (LZ_BLANK && (idx_q != 2'd0) && lead_zero) begin
      seg_d = 8'hFF;
    end
    if (blink_en && !clk_blink) begin
      an_d  = 4'hF;
      seg_d = 8'hFF;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      digits_q  <= '0;
      ref_cnt_q <= '0;
      idx_q     <= '0;
      seg_q     <= 8'hFF;
      an_q      <= 4'hF;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      digits_q  <= digits_d;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign busy = (state_q == ST_CONV);
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Two instances (leading-zero blanking off and on) share one stimulus stream.
//   A posedge sampler keeps a reference model of what the meter should show:
//   accepted loads push the expected decimal value and its completion cycle
//   onto a queue. A negedge monitor compares the display, busy, and pops the
//   queue whenever the DUT signals completion (busy falling).
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic        load;
  logic        blink_en;
  logic        clk_blink;
  logic [13:0] value_in;
  logic        busy, busy_lz;
  logic [7:0]  seg, seg_lz;
  logic [3:0]  an, an_lz;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) u_dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .blink_en(blink_en), .clk_blink(clk_blink),
    .busy(busy), .seg(seg), .an(an)
  );

  seg7_scan_driver #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) u_dut_lz (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .blink_en(blink_en), .clk_blink(clk_blink),
    .busy(busy_lz), .seg(seg_lz), .an(an_lz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int val;
    int fall;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int pow10 [4] = '{1, 10, 100, 1000};

  // Reference model state, updated at each posedge.
  int cyc         = 0;
  int scan_edges  = -1;
  int busy_last   = -1;
  bit exp_busy    = 1'b0;
  bit exp_blank   = 1'b0;
  bit last_rst    = 1'b1;
  bit model_valid = 1'b0;
  int smp_v;
  exp_t smp_e;

  // Monitor state.
  int   disp_val  = 0;
  logic prev_busy = 1'b0;
  int   slot;
  logic [11:0] e_disp;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Expected {an, seg} for decimal value v shown in digit slot s.
  function automatic logic [11:0] exp_disp(input int v, input int s, input bit blank, input bit lz);
    logic [3:0] a;
    logic [7:0] sg;
    if (blank) return {4'hF, 8'hFF};
    a     = 4'hF;
    a[s]  = 1'b0;
    sg    = seg_tbl[(v / pow10[s]) % 10];
    if (lz && s != 0 && v < pow10[s]) sg = 8'hFF;
    return {a, sg};
  endfunction

  always @(posedge clk) begin
    cyc++;
    model_valid = 1'b1;
    if (!rst) begin
      last_rst   = 1'b1;
      scan_edges = -1;
      busy_last  = -1;
      exp_q.delete();
    end else begin
      last_rst = 1'b0;
      scan_edges++;
      if (load && !exp_busy) begin
        smp_v      = (int'(value_in) > 9999) ? 9999 : int'(value_in);
        smp_e.val  = smp_v;
        smp_e.fall = cyc + 14;
        exp_q.push_back(smp_e);
        busy_last  = cyc + 13;
      end
    end
    exp_busy  = (cyc <= busy_last);
    exp_blank = blink_en && !clk_blink;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      if (last_rst) begin
        check("an_reset", an, 4'hF);
        check("seg_reset", seg, 8'hFF);
        check("an_lz_reset", an_lz, 4'hF);
        check("seg_lz_reset", seg_lz, 8'hFF);
      end else begin
        slot   = (scan_edges / DIV) % 4;
        e_disp = exp_disp(disp_val, slot, exp_blank, 1'b0);
        check("an", an, e_disp[11:8]);
        check("seg", seg, e_disp[7:0]);
        e_disp = exp_disp(disp_val, slot, exp_blank, 1'b1);
        check("an_lz", an_lz, e_disp[11:8]);
        check("seg_lz", seg_lz, e_disp[7:0]);
      end
      check("busy", busy, exp_busy);
      check("busy_lz", busy_lz, exp_busy);

      if (last_rst) begin
        disp_val = 0;
      end else if (prev_busy && !busy) begin
        check("pending_on_done", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("done_cycle", mon_e.fall, cyc);
          disp_val = mon_e.val;
        end
      end
      prev_busy = busy;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input int v);
    load     = 1'b1;
    value_in = 14'(v);
    tick();
    load     = 1'b0;
  endtask

  function automatic int rand_value();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 99));
      1:       return int'($urandom_range(0, 9999));
      2:       return int'($urandom_range(9990, 16383));
      default: return int'($urandom_range(0, 16383));
    endcase
  endfunction

  initial begin
    rst       = 1'b0;
    load      = 1'b0;
    blink_en  = 1'b0;
    clk_blink = 1'b0;
    value_in  = '0;

    // Reset, then a full scan of zeros.
    tick(3);
    rst = 1'b1;
    tick(20);

    // Basic conversion.
    do_load(1234);
    tick(36);

    // Saturation and zero.
    do_load(12000);
    tick(35);
    do_load(0);
    tick(35);

    // Load while busy is dropped.
    do_load(5);
    tick(2);
    do_load(77);
    tick(35);

    // Load on the cycle busy falls is ignored; the next cycle is accepted.
    do_load(100);
    tick(13);
    do_load(42);
    do_load(9999);
    tick(35);
    do_load(10000);
    tick(20);

    // Blinking, then blink_en low with clk_blink wandering.
    blink_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) clk_blink = ~clk_blink;
      tick();
    end
    blink_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk_blink = 1'($urandom);
      tick();
    end

    // Reset on the seventh conversion cycle.
    do_load(4321);
    tick(6);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(20);

    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      blink_en  = ($urandom_range(0, 3) == 0);
      clk_blink = 1'($urandom);
      do_load(rand_value());
      for (int j = 0; j < int'($urandom_range(0, 25)); j++) begin
        if ($urandom_range(0, 4) == 0) clk_blink = ~clk_blink;
        if ($urandom_range(0, 60) == 0) rst = 1'b0;
        tick();
        rst = 1'b1;
      end
    end
    blink_en = 1'b0;
    tick(40);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
